// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
// 8N1 serial receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
// Recovers bytes from an asynchronous RX line into the clk domain and delivers each
// good byte with a one-cycle valid strobe; a low stop bit gives a one-cycle
// framing_error strobe instead.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   port           in   serial RX line, asynchronous to clk, idles high
//   data           out  [7:0] last correctly received byte, held until the next good frame
//   valid          out  one-cycle strobe, data updated this cycle
//   framing_error  out  one-cycle strobe, stop bit sampled low
//   active         out  high while a frame is in progress (START, DATA, STOP)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for rx_sync to fall
// START      | waiting for start-bit mid-point; high there means glitch
// DATA       | sampling 8 data bits, one every CLKS_PER_BIT cycles
// STOP       | sampling stop bit; high -> valid, low -> framing_error
// BREAK_WAIT | after a framing error, wait for the line to return high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 12000000 / 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       port,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       active
);

  localparam int          HALF   = CLKS_PER_BIT / 2;
  localparam logic [31:0] HALF_M1 = 32'(HALF - 1);
  localparam logic [31:0] BIT_M1  = 32'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic        sync_meta_q, sync_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic [31:0] clock_count_q, clock_count_d;
  logic [2:0]  bit_index_q, bit_index_d;
  logic [7:0]  shift_reg_q, shift_reg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        framing_error_q, framing_error_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      sync_meta_q     <= 1'b1;
      rx_sync_q       <= 1'b1;
      clock_count_q   <= '0;
      bit_index_q     <= '0;
      shift_reg_q     <= '0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync_meta_q     <= sync_meta_d;
      rx_sync_q       <= rx_sync_d;
      clock_count_q   <= clock_count_d;
      bit_index_q     <= bit_index_d;
      shift_reg_q     <= shift_reg_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  always_comb begin
    sync_meta_d     = port;
    rx_sync_d       = sync_meta_q;
    state_d         = state_q;
    clock_count_d   = clock_count_q + 32'd1;
    bit_index_d     = bit_index_q;
    shift_reg_d     = shift_reg_q;
    data_d          = data_q;
    valid_d         = 1'b0;
    framing_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        clock_count_d = '0;
        if (!rx_sync_q) state_d = S_START;
      end

      S_START: begin
        if (clock_count_q == HALF_M1) begin
          clock_count_d = '0;
          state_d       = rx_sync_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (clock_count_q == BIT_M1) begin
          clock_count_d            = '0;
          shift_reg_d[bit_index_q] = rx_sync_q;
          if (bit_index_q == 3'd7) begin
            bit_index_d = '0;
            state_d     = S_STOP;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (clock_count_q == BIT_M1) begin
          clock_count_d = '0;
          if (rx_sync_q) begin
            data_d  = shift_reg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = S_BREAK_WAIT;
          end
        end
      end

      // A held-low line must not be mistaken for a stream of new start bits.
      S_BREAK_WAIT: begin
        clock_count_d = '0;
        if (rx_sync_q) state_d = S_IDLE;
      end

      default: begin
        clock_count_d = '0;
        bit_index_d   = '0;
        state_d       = S_IDLE;
      end
    endcase
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = framing_error_q;
  assign active        = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam realtime CLK_NS  = 10.0;
  localparam realtime BIT_NS  = 160.0;   // 16 clocks per bit
  localparam realtime BIT_DEF = 1040.0;  // 104 clocks per bit (default parameter)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       port16 = 1'b1;
  logic       port_def = 1'b1;
  logic [7:0] data16, data_def;
  logic       valid16, valid_def;
  logic       fe16, fe_def;
  logic       active16, active_def;

  always #(CLK_NS / 2) clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .reset(reset_n), .port(port16),
    .data(data16), .valid(valid16), .framing_error(fe16), .active(active16)
  );

  uart_receiver dut_def (
    .clk(clk), .reset(reset_n), .port(port_def),
    .data(data_def), .valid(valid_def), .framing_error(fe_def), .active(active_def)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         valid_cnt = 0, fe_cnt = 0, both_cnt = 0;
  logic [7:0] last_data = 8'h00;
  int         valid_cnt_def = 0, fe_cnt_def = 0;
  logic [7:0] last_data_def = 8'h00;

  always @(negedge clk) begin
    if (valid16) begin
      valid_cnt = valid_cnt + 1;
      last_data = data16;
    end
    if (fe16) fe_cnt = fe_cnt + 1;
    if (valid16 && fe16) both_cnt = both_cnt + 1;
    if (valid_def) begin
      valid_cnt_def = valid_cnt_def + 1;
      last_data_def = data_def;
    end
    if (fe_def) fe_cnt_def = fe_cnt_def + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_line(input int which, input logic v);
    if (which == 0) port16 = v;
    else            port_def = v;
  endtask

  // Leaves the line at the stop-bit level when the task returns.
  task automatic send_frame(input int which, input logic [7:0] b, input logic stop_bit,
                            input realtime bit_ns);
    drive_line(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      drive_line(which, b[i]);
      #(bit_ns);
    end
    drive_line(which, stop_bit);
    #(bit_ns);
  endtask

  typedef struct {
    string      name;
    logic [7:0] tx;
    realtime    bit_ns;
    int         gap_cyc;
    int         exp_valid;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0;

    vecs[0] = '{"a5_nominal", 8'hA5, BIT_NS,         20, 1, 0, 8'hA5};
    vecs[1] = '{"b2b_00",     8'h00, BIT_NS,          0, 1, 0, 8'h00};
    vecs[2] = '{"b2b_ff",     8'hFF, BIT_NS,          0, 1, 0, 8'hFF};
    vecs[3] = '{"b2b_55",     8'h55, BIT_NS,         20, 1, 0, 8'h55};
    vecs[4] = '{"96_plus3",   8'h96, BIT_NS * 1.03,  20, 1, 0, 8'h96};
    vecs[5] = '{"96_minus3",  8'h96, BIT_NS * 0.97,  20, 1, 0, 8'h96};

    repeat (3) @(negedge clk);
    check("rst_data",   {24'h0, data16}, 32'h0);
    check("rst_valid",  {31'h0, valid16}, 32'h0);
    check("rst_fe",     {31'h0, fe16}, 32'h0);
    check("rst_active", {31'h0, active16}, 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      f0 = fe_cnt;
      send_frame(0, vecs[i].tx, 1'b1, vecs[i].bit_ns);
      if (vecs[i].gap_cyc > 0) repeat (vecs[i].gap_cyc) @(negedge clk);
      check({vecs[i].name, "_valid"}, 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check({vecs[i].name, "_fe"},    32'(fe_cnt - f0),    32'(vecs[i].exp_fe));
      check({vecs[i].name, "_data"},  {24'h0, last_data},  {24'h0, vecs[i].exp_data});
    end

    // Short low pulse: rejected at the start-bit mid-point.
    v0 = valid_cnt;
    f0 = fe_cnt;
    port16 = 1'b0;
    repeat (4) @(negedge clk);
    port16 = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_valid",  32'(valid_cnt - v0), 32'd0);
    check("glitch_fe",     32'(fe_cnt - f0), 32'd0);
    check("glitch_active", {31'h0, active16}, 32'h0);

    // Bad stop bit followed by a break: one error, data keeps 0x96.
    v0 = valid_cnt;
    f0 = fe_cnt;
    send_frame(0, 8'h3C, 1'b0, BIT_NS);
    #(BIT_NS * 3.0);
    @(negedge clk);
    check("break_active", {31'h0, active16}, 32'h0);
    port16 = 1'b1;
    repeat (20) @(negedge clk);
    check("break_fe",    32'(fe_cnt - f0), 32'd1);
    check("break_valid", 32'(valid_cnt - v0), 32'd0);
    check("break_data",  {24'h0, data16}, 32'h96);
    send_frame(0, 8'h81, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    check("after_break_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_break_data",  {24'h0, last_data}, 32'h81);

    // Reset in the middle of data bit 4 (0x7E).
    v0 = valid_cnt;
    f0 = fe_cnt;
    port16 = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      port16 = ((8'h7E >> i) & 8'h01) != 0;
      #(BIT_NS);
    end
    port16 = 1'b1;
    #(BIT_NS / 2);
    check("mid_frame_active", {31'h0, active16}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_data",   {24'h0, data16}, 32'h0);
    check("rst_mid_valid",  {31'h0, valid16}, 32'h0);
    check("rst_mid_fe",     {31'h0, fe16}, 32'h0);
    check("rst_mid_active", {31'h0, active16}, 32'h0);
    #(BIT_NS * 6.0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_strobe", 32'(valid_cnt - v0 + fe_cnt - f0), 32'd0);
    send_frame(0, 8'h7E, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    check("after_rst_valid", 32'(valid_cnt - v0), 32'd1);
    check("after_rst_data",  {24'h0, last_data}, 32'h7E);

    check("valid_and_fe_together", 32'(both_cnt), 32'd0);

    // Default-rate instance, 104 clocks per bit.
    send_frame(1, 8'hA5, 1'b1, BIT_DEF);
    repeat (20) @(negedge clk);
    check("def_valid", 32'(valid_cnt_def), 32'd1);
    check("def_fe",    32'(fe_cnt_def), 32'd0);
    check("def_data",  {24'h0, last_data_def}, 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
